// File: rtl/tdm_demux_if.sv
// Link-side bundle for the 4-slot TDM demultiplexer: input word stream plus per-slot outputs.
// Latency: n/a (wiring only); outputs are registered inside the demux.
// Backpressure: none; the link source never stalls.
interface tdm_demux_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] demux_out_0;
  logic [WIDTH-1:0] demux_out_1;
  logic [WIDTH-1:0] demux_out_2;
  logic [WIDTH-1:0] demux_out_3;
  logic [3:0]       demux_valid;
  logic             frame_done;
  logic             locked;
  logic             sync_err;

  // Link source side: drives the word stream, observes the channel outputs.
  modport master (
    output din, din_valid, frame_sync,
    input  demux_out_0, demux_out_1, demux_out_2, demux_out_3,
    input  demux_valid, frame_done, locked, sync_err
  );

  // Demultiplexer side.
  modport slave (
    input  din, din_valid, frame_sync,
    output demux_out_0, demux_out_1, demux_out_2, demux_out_3,
    output demux_valid, frame_done, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux.sv
// 4-slot TDM demultiplexer: frame-sync acquisition (HUNT/LOCK), routes each word to its slot output.
// Latency: 1 cycle from sampled beat to demux_out_k / demux_valid / frame_done / sync_err.
// Backpressure: none; accepts one word per cycle. TDM_DEMUX_STRICT_SYNC_EN selects strict slot-0 sync.
module tdm_demux #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux_if.slave   bus
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] out_q [4];
  logic [WIDTH-1:0] out_d [4];
  logic [3:0]       vld_q, vld_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  // Per-beat decision: which slot (if any) is written, strobes, and next frame position.
  always_comb begin
    logic       wr_en;
    logic [1:0] wr_idx;
    wr_en   = 1'b0;
    wr_idx  = 2'd0;
    state_d = state_q;
    slot_d  = slot_q;
    out_d   = out_q;
    vld_d   = 4'b0000;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (bus.din_valid) begin
      if (state_q == HUNT) begin
        // Only a sync-qualified word can start a frame; everything else is dropped.
        if (bus.frame_sync) begin
          wr_en   = 1'b1;
          wr_idx  = 2'd0;
          slot_d  = 2'd1;
          state_d = LOCK;
        end
      end else if (bus.frame_sync) begin
        // Sync always realigns to slot 0; arriving mid-frame it is flagged as early.
        err_d  = (slot_q != 2'd0);
        wr_en  = 1'b1;
        wr_idx = 2'd0;
        slot_d = 2'd1;
      end else if (slot_q != 2'd0) begin
        wr_en  = 1'b1;
        wr_idx = slot_q;
        done_d = (slot_q == 2'd3);
        slot_d = slot_q + 2'd1;
      end else begin
`ifdef TDM_DEMUX_STRICT_SYNC_EN
        // Slot 0 without sync means framing is lost: drop the word and re-hunt.
        err_d   = 1'b1;
        state_d = HUNT;
        slot_d  = 2'd0;
`else
        // Flywheel: keep counting through a missing sync marker.
        wr_en  = 1'b1;
        wr_idx = 2'd0;
        slot_d = 2'd1;
`endif
      end
    end

    if (wr_en) begin
      out_d[wr_idx] = bus.din;
      vld_d[wr_idx] = 1'b1;
    end

    locked_d = (state_d == LOCK);
  end

  // State, slot counter and all registered outputs; reset overrides any in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= 2'd0;
      for (int k = 0; k < 4; k++) out_q[k] <= '0;
      vld_q    <= 4'b0000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      for (int k = 0; k < 4; k++) out_q[k] <= out_d[k];
      vld_q    <= vld_d;
      done_q   <= done_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign bus.demux_out_0 = out_q[0];
  assign bus.demux_out_1 = out_q[1];
  assign bus.demux_out_2 = out_q[2];
  assign bus.demux_out_3 = out_q[3];
  assign bus.demux_valid = vld_q;
  assign bus.frame_done  = done_q;
  assign bus.sync_err    = err_q;
  assign bus.locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed vector table for the framing corner cases, then random beats vs a model.
// Latency: each beat is checked one cycle after the edge that samples it.
// Backpressure: none; stimulus may present a word every cycle.
module tb_tdm_demux;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_demux_if #(.WIDTH(W)) bus ();

  tdm_demux #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic            r;
    logic            v;
    logic            s;
    logic [W-1:0]    d;
    logic [3:0]      dv;
    logic            fd;
    logic            lk;
    logic            se;
    logic [3:0][W-1:0] o;
  } vec_t;

  vec_t              tbl[$];
  logic [3:0][W-1:0] cur;
  int                vectors = 0;
  int                miscompares = 0;

  // Append a vector; expected channel words follow from the expected strobes.
  task automatic add(input logic r, v, s, input logic [W-1:0] d,
                     input logic [3:0] dv, input logic fd, lk, se);
    vec_t t;
    if (r) cur = '0;
    else for (int k = 0; k < 4; k++) if (dv[k]) cur[k] = d;
    t.r = r; t.v = v; t.s = s; t.d = d;
    t.dv = dv; t.fd = fd; t.lk = lk; t.se = se; t.o = cur;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic r, v, s, input logic [W-1:0] d);
    @(negedge clk);
    rst            = r;
    bus.din_valid  = v;
    bus.frame_sync = s;
    bus.din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int id, input logic [3:0][W-1:0] eo,
                       input logic [3:0] edv, input logic efd, elk, ese);
    logic [3:0][W-1:0] ao;
    ao = {bus.demux_out_3, bus.demux_out_2, bus.demux_out_1, bus.demux_out_0};
    vectors++;
    if (ao !== eo || bus.demux_valid !== edv || bus.frame_done !== efd ||
        bus.locked !== elk || bus.sync_err !== ese) begin
      miscompares++;
      $display("FAIL vec%0d: got out=%h dv=%b fd=%b lk=%b se=%b, want out=%h dv=%b fd=%b lk=%b se=%b",
               id, ao, bus.demux_valid, bus.frame_done, bus.locked, bus.sync_err,
               eo, edv, efd, elk, ese);
    end
  endtask

  // Reference model state: lock flag, next frame position, last word per channel.
  bit                m_lock;
  int                m_pos;
  logic [3:0][W-1:0] m_out;

  initial begin
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    cur            = '0;

    // Reset state.
    add(1, 0, 0, 8'h00, 4'b0000, 0, 0, 0);
    // Acquire and stream: unsynced words ignored, then A0..A3.
    add(0, 1, 0, 8'h11, 4'b0000, 0, 0, 0);
    add(0, 1, 0, 8'h22, 4'b0000, 0, 0, 0);
    add(0, 1, 0, 8'h33, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 8'hA0, 4'b0001, 0, 1, 0);
    add(0, 1, 0, 8'hA1, 4'b0010, 0, 1, 0);
    add(0, 1, 0, 8'hA2, 4'b0100, 0, 1, 0);
    add(0, 1, 0, 8'hA3, 4'b1000, 1, 1, 0);
    // Gapped frame: two idle cycles between beats; sync during idle is ignored.
    for (int k = 0; k < 4; k++) begin
      add(0, 1, (k == 0), 8'hA0 + 8'(k), 4'b0001 << k, (k == 3), 1, 0);
      add(0, 0, 1, 8'h5A, 4'b0000, 0, 1, 0);
      add(0, 0, 0, 8'hC3, 4'b0000, 0, 1, 0);
    end
    // Early sync: B0, B1, then C0 with sync mid-frame.
    add(0, 1, 1, 8'hB0, 4'b0001, 0, 1, 0);
    add(0, 1, 0, 8'hB1, 4'b0010, 0, 1, 0);
    add(0, 1, 1, 8'hC0, 4'b0001, 0, 1, 1);
    add(0, 1, 0, 8'h55, 4'b0010, 0, 1, 0);
    add(0, 1, 0, 8'h56, 4'b0100, 0, 1, 0);
    add(0, 1, 0, 8'h57, 4'b1000, 1, 1, 0);
    // Missing sync at a frame boundary.
`ifdef TDM_DEMUX_STRICT_SYNC_EN
    add(0, 1, 0, 8'hD0, 4'b0000, 0, 0, 1);
`else
    add(0, 1, 0, 8'hD0, 4'b0001, 0, 1, 0);
`endif
    // Reset mid-frame, with an in-flight beat that must be dropped.
    add(1, 0, 0, 8'h00, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 8'h70, 4'b0001, 0, 1, 0);
    add(0, 1, 0, 8'h71, 4'b0010, 0, 1, 0);
    add(1, 1, 1, 8'h99, 4'b0000, 0, 0, 0);
    add(0, 1, 0, 8'hE2, 4'b0000, 0, 0, 0);
    add(0, 1, 1, 8'hF0, 4'b0001, 0, 1, 0);
    add(0, 0, 0, 8'h00, 4'b0000, 0, 1, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
      check(i, tbl[i].o, tbl[i].dv, tbl[i].fd, tbl[i].lk, tbl[i].se);
    end

    // Random stream against the frame-position model.
    m_lock = 0; m_pos = 0; m_out = '0;
    for (int n = 0; n < 3000; n++) begin
      logic             r, v, s;
      logic [W-1:0]     d;
      logic [3:0]       edv;
      logic             efd, ese;
      r = (n == 0) || ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 7);
      s = (m_pos == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
      d = W'($urandom);
      edv = 4'b0000; efd = 0; ese = 0;
      if (r) begin
        m_lock = 0; m_pos = 0; m_out = '0;
      end else if (v) begin
        if (!m_lock) begin
          if (s) begin
            m_out[0] = d; edv[0] = 1; m_lock = 1; m_pos = 1;
          end
        end else if (s || m_pos != 0) begin
          int p;
          ese = s && (m_pos != 0);
          p = s ? 0 : m_pos;
          m_out[p] = d; edv[p] = 1;
          efd = (p == 3);
          m_pos = (p + 1) % 4;
        end else begin
`ifdef TDM_DEMUX_STRICT_SYNC_EN
          ese = 1; m_lock = 0; m_pos = 0;
`else
          m_out[0] = d; edv[0] = 1; m_pos = 1;
`endif
        end
      end
      drive(r, v, s, d);
      check(1000 + n, m_out, edv, efd, m_lock, ese);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of a 4-slot TDM link whose transmit end is built from the team's multiplexers. It accepts one WIDTH-bit word per valid beat and tracks frame position from a frame-sync marker. It routes each word to the channel output for its slot and raises a one-cycle strobe per channel update. It sits between the link input and the four per-channel consumers.

## Interface
- WIDTH, 8, data word width in bits (>= 1)
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- din  input  WIDTH  multiplexed data word
- din_valid  input  1  din carries a slot word this cycle
- frame_sync  input  1  qualifies din as slot 0; ignored when din_valid=0
- demux_out_0..demux_out_3  output  WIDTH each  registered word for slot 0..3; holds until next update
- demux_valid  output  4  bit k pulses for one cycle when demux_out_k updates
- frame_done  output  1  one-cycle pulse when slot 3 is written
- locked  output  1  high while in LOCK state
- sync_err  output  1  one-cycle pulse on a framing violation

## Operation
- States: HUNT and LOCK. There is a 2-bit slot counter `slot`, which holds the next expected slot.
- Reset values: state=HUNT, slot=0, all demux_out_k=0, demux_valid=0, frame_done=0, locked=0, sync_err=0.
- HUNT:
  - Beats with din_valid=1 and frame_sync=0 are discarded with no output.
  - A beat with din_valid=1 and frame_sync=1 writes demux_out_0 and pulses demux_valid[0].
  - On that beat: slot becomes 1 and the state moves to LOCK.
- LOCK, beat with din_valid=1:
  - frame_sync=0 and slot != 0: write demux_out_slot, pulse demux_valid[slot], then slot <= slot+1 (mod 4).
  - frame_sync=1 and slot == 0: normal slot-0 write, then slot <= 1.
  - frame_sync=1 and slot != 0 (early sync): pulse sync_err and treat the beat as slot 0. This writes demux_out_0, pulses demux_valid[0] and sets slot <= 1. The state stays LOCK.
  - frame_sync=0 and slot == 0 (missing sync): behaviour is set by the Configuration macro.
- When slot 3 is written, frame_done pulses and slot wraps to 0.
- din_valid=0: no state change, no strobes, and outputs hold their values.
- Only one demux_valid bit can be high in any cycle.
- Outputs not being written keep their previous value, including across sync_err and a return to HUNT.
- locked = (state == LOCK), driven from a register.

## Timing
- Latency is 1 cycle. A beat sampled at edge N appears on demux_out_k, demux_valid, frame_done and sync_err after edge N. All of these are registered outputs.
- Full throughput: one word per cycle with din_valid held high. There is no backpressure and no input stall.
- locked rises in the same cycle as the first demux_valid[0] pulse after HUNT.
- rst=1 at any edge, including mid-frame, overrides every other input. It loads the reset values at that edge, and the in-flight beat is dropped. The first beat after rst deasserts is evaluated in HUNT.
- Simultaneous events:
  - sync_err and demux_valid[0] pulse in the same cycle.
  - frame_done never coincides with sync_err.

## Configuration
- Macro: TDM_DEMUX_STRICT_SYNC_EN.
- Defined (strict): frame_sync is required on every slot-0 beat. A missing-sync beat in LOCK:
  - pulses sync_err and writes no output;
  - sets state=HUNT and slot=0, so locked falls after that edge.
- Undefined (flywheel): frame_sync is required only to acquire lock. A missing-sync beat in LOCK is accepted as a normal slot-0 write with no sync_err.
- Early-sync handling is identical in both builds.

## Test plan
- Acquire and stream. After rst, drive 3 beats without sync (0x11, 0x22, 0x33), then 4 beats (0xA0 with sync, 0xA1, 0xA2, 0xA3).
  - No strobes for the first three beats.
  - demux_out_0..3 = A0/A1/A2/A3, with demux_valid = 1,2,4,8 on consecutive cycles.
  - frame_done pulses with slot 3; locked = 1.
- Gapped input. Same frame with din_valid low for 2 cycles between each beat.
  - Identical outputs to the streaming case, with strobes only on the cycle after each valid beat.
  - frame_sync asserted with din_valid=0 has no effect.
- Early sync. While locked, drive 0xB0 (sync), 0xB1, then 0xC0 with sync.
  - sync_err and demux_valid[0] pulse together; demux_out_0 = 0xC0.
  - demux_out_2 and demux_out_3 keep their prior values; the next beat lands in slot 1.
- Missing sync at a frame boundary, after a complete frame, with next beat 0xD0 and frame_sync=0.
  - Flywheel build: demux_out_0 = 0xD0 and no sync_err.
  - Strict build: sync_err pulses, demux_out_0 is unchanged and locked drops to 0.
- Reset mid-frame. Assert rst after slot 1 of a frame.
  - All outputs return to 0 and locked = 0.
  - After deassert, a beat 0xE2 without sync is ignored, and a beat 0xF0 with sync re-acquires lock.
